// File: rtl/fsm_timer_if.sv
// Control/status bundle for fsm_timer: the master drives run requests,
// the slave (the timer) reports progress and status back.
interface fsm_timer_if #(
  parameter int CNT_W = 7
);
  logic             go;
  logic             kill;
  logic             pause;
  logic             auto;
  logic [CNT_W-1:0] term;
  logic             done;
  logic             busy;
  logic             aborted;
  logic [CNT_W-1:0] count;
  logic [2:0]       state;

  modport master (
    output go, kill, pause, auto, term,
    input  done, busy, aborted, count, state
  );

  modport slave (
    input  go, kill, pause, auto, term,
    output done, busy, aborted, count, state
  );
endinterface

// File: rtl/fsm_timer.sv
// Programmable-length run/abort timer: go starts a count up to a latched
// terminal value, done pulses for the single FINISH cycle, with pause,
// level-sensitive kill and optional auto-restart.
module fsm_timer #(
  parameter int CNT_W = 7
) (
  input  logic        clk,
  input  logic        reset,
  fsm_timer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACTIVE = 3'd1,
    S_PAUSE  = 3'd2,
    S_FINISH = 3'd3,
    S_ABORT  = 3'd4
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_term_q;
  logic             r_auto_q;
  logic             r_done;
  logic             r_busy;
  logic             r_aborted;

  // Single-process FSM; every output is a flop updated alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_term_q  <= '0;
      r_auto_q  <= 1'b0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // go together with kill is treated as no request at all
          if (bus.go && !bus.kill) begin
            r_state   <= S_ACTIVE;
            r_count   <= '0;
            r_term_q  <= bus.term;
            r_auto_q  <= bus.auto;
            r_aborted <= 1'b0;
            r_busy    <= 1'b1;
          end
        end
        S_ACTIVE: begin
          if (bus.kill) begin
            r_state   <= S_ABORT;
            r_count   <= '0;
            r_aborted <= 1'b1;
            r_busy    <= 1'b0;
          end else if (r_count == r_term_q) begin
            // terminal reached: count is cleared rather than incremented
            r_state <= S_FINISH;
            r_count <= '0;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else if (bus.pause) begin
            r_state <= S_PAUSE;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        S_PAUSE: begin
          if (bus.kill) begin
            r_state   <= S_ABORT;
            r_count   <= '0;
            r_aborted <= 1'b1;
            r_busy    <= 1'b0;
          end else if (!bus.pause) begin
            // count is held here; it advances on the following ACTIVE cycle
            r_state <= S_ACTIVE;
          end
        end
        S_FINISH: begin
          r_count <= '0;
          if (r_auto_q && !bus.kill) begin
            r_state  <= S_ACTIVE;
            r_term_q <= bus.term;
            r_auto_q <= bus.auto;
            r_busy   <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ABORT: begin
          r_count <= '0;
          if (!bus.kill) r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_count <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.done    = r_done;
  assign bus.busy    = r_busy;
  assign bus.aborted = r_aborted;
  assign bus.count   = r_count;
  assign bus.state   = r_state;

endmodule
